// File: rtl/nios2_oci_trace_capture_if.sv
// Read-side handshake bundle for the trace-capture buffer.
// The buffer drives valid/data (master); the consumer drives ready (slave).
interface nios2_oci_trace_capture_if #(
    parameter int DATA_W = 30,
    parameter int CNT_W  = 4
);
    logic                    rd_valid;
    logic                    rd_ready;
    logic [CNT_W+DATA_W-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/nios2_oci_trace_capture.sv
// Trace-capture buffer for the Nios II OCI debug path.
// Captures each completed trace word (and a partial word on end-of-test flush)
// into a circular buffer drained through a first-word-fall-through read port.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | normal capture; full trace words are pushed
// FLUSH | one cycle; push the partial word left in dct_buffer, if any
// ENDED | capture frozen; reads still drain; left only by reset/clear
module nios2_oci_trace_capture #(
    parameter int DATA_W    = 30,
    parameter int CNT_W     = 4,
    parameter int FULL_CNT  = 15,
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int WRAP_MODE = 0
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [DATA_W-1:0]               dct_buffer,
    input  logic [CNT_W-1:0]                dct_count,
    input  logic                            test_ending,
    input  logic                            test_has_ended,
    input  logic                            clear,
    nios2_oci_trace_capture_if.master       rd_if,
    output logic [AW:0]                     level,
    output logic [15:0]                     drop_cnt,
    output logic                            ended
);

    localparam int                EW       = CNT_W + DATA_W;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FULL_CNT);
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [AW:0]       LVL_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_ENDED = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic              ending_q;

    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level_q;
    logic [15:0]       drop_q;

    logic              capture_evt;
    logic              push;
    logic              pop;
    logic              full;
    logic              soft_clear;

    // A count that sits at FULL_CNT for several cycles is one word, not many.
    assign capture_evt = (dct_count == CNT_FULL) && (cnt_q != CNT_FULL);
    assign full        = (level_q == LVL_FULL);
    assign pop         = (level_q != '0) && rd_if.rd_ready;
    assign soft_clear  = clear;

    // Next-state and push decision for the capture controller.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                push = capture_evt;
                if (test_has_ended) begin
                    state_d = ST_ENDED;
                end else if (test_ending && !ending_q) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Partial words always flush; a full count only on a fresh event
                // so a word already captured in RUN is not duplicated.
                if (dct_count == CNT_FULL) begin
                    push = capture_evt;
                end else if (dct_count != CNT_ZERO) begin
                    push = 1'b1;
                end
                state_d = ST_ENDED;
            end
            ST_ENDED: begin
                state_d = ST_ENDED;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State register and one-cycle input history.
    always_ff @(posedge clk) begin
        if (!reset_n || soft_clear) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            ending_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= dct_count;
            ending_q <= test_ending;
        end
    end

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (reset_n && !soft_clear && push && (!full || pop || (WRAP_MODE != 0))) begin
            mem[wr_ptr] <= {dct_count, dct_buffer};
        end
    end

    // Pointer, occupancy and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (!reset_n || soft_clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            drop_q  <= '0;
        end else begin
            if (push && pop) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                rd_ptr <= rd_ptr + PTR_ONE;
            end else if (push && !full) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                level_q <= level_q + LVL_ONE;
            end else if (push) begin
                // Full with no pop: either drop the new word or evict the oldest.
                if (WRAP_MODE != 0) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end else if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                level_q <= level_q - LVL_ONE;
            end
        end
    end

    assign rd_if.rd_valid = (level_q != '0);
    assign rd_if.rd_data  = mem[rd_ptr];
    assign level          = level_q;
    assign drop_cnt       = drop_q;
    assign ended          = (state_q == ST_ENDED);

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
module tb_nios2_oci_trace_capture;
    localparam int DATA_W = 30;
    localparam int CNT_W  = 4;
    localparam int AW     = 4;
    localparam int EW     = CNT_W + DATA_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [DATA_W-1:0] dct_buffer = '0;
    logic [CNT_W-1:0]  dct_count = '0;
    logic              test_ending = 1'b0;
    logic              test_has_ended = 1'b0;
    logic              clear = 1'b0;
    logic              rd_ready = 1'b0;

    logic [AW:0]       lvl [2];
    logic [15:0]       drp [2];
    logic              end_o [2];
    logic              vld [2];
    logic [EW-1:0]     rdd [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios2_oci_trace_capture_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if0 ();
    nios2_oci_trace_capture_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) if1 ();

    assign if0.rd_ready = rd_ready;
    assign if1.rd_ready = rd_ready;
    assign vld[0] = if0.rd_valid;
    assign vld[1] = if1.rd_valid;
    assign rdd[0] = if0.rd_data;
    assign rdd[1] = if1.rd_data;

    nios2_oci_trace_capture #(.WRAP_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .clear(clear),
        .rd_if(if0), .level(lvl[0]), .drop_cnt(drp[0]), .ended(end_o[0])
    );

    nios2_oci_trace_capture #(.WRAP_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .clear(clear),
        .rd_if(if1), .level(lvl[1]), .drop_cnt(drp[1]), .ended(end_o[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] d);
        dct_count  = 4'd15;
        dct_buffer = d;
        step();
        dct_count  = 4'd0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lvl[d] !== 5'd0 || vld[d] !== 1'b0 || drp[d] !== 16'd0 || end_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: level=%0d valid=%b drop=%0d ended=%b, want 0/0/0/0",
                         d, lvl[d], vld[d], drp[d], end_o[d]);
            end
        end
    endtask

    task automatic test_single_capture();
        for (int i = 0; i < 15; i++) begin
            dct_count  = 4'(i);
            dct_buffer = 30'(i);
            step();
        end
        checks++;
        if (lvl[0] !== 5'd0) begin
            errors++;
            $display("FAIL ramp_no_push: level=%0d want 0", lvl[0]);
        end
        dct_count  = 4'd15;
        dct_buffer = 30'h2AAAAAAA;
        for (int c = 0; c < 3; c++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (lvl[d] !== 5'd1 || vld[d] !== 1'b1 || rdd[d] !== {4'hF, 30'h2AAAAAAA}) begin
                    errors++;
                    $display("FAIL single_capture dut%0d cyc%0d: level=%0d valid=%b data=%h want 1/1/%h",
                             d, c, lvl[d], vld[d], rdd[d], {4'hF, 30'h2AAAAAAA});
                end
            end
        end
        dct_count = 4'd0;
        rd_ready  = 1'b1;
        step();
        rd_ready  = 1'b0;
        checks++;
        if (lvl[0] !== 5'd0 || vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_pop: level=%0d valid=%b want 0/0", lvl[0], vld[0]);
        end
    endtask

    task automatic test_full_wrap();
        logic [EW-1:0] exp;
        for (int i = 0; i < 16; i++) push_word(30'h100 + 30'(i));
        checks++;
        if (lvl[0] !== 5'd16 || lvl[1] !== 5'd16 || drp[0] !== 16'd0) begin
            errors++;
            $display("FAIL fill16: level0=%0d level1=%0d drop0=%0d want 16/16/0", lvl[0], lvl[1], drp[0]);
        end
        push_word(30'h110);
        for (int d = 0; d < 2; d++) begin
            exp = {4'hF, 30'h100 + 30'(d)};
            checks++;
            if (lvl[d] !== 5'd16 || drp[d] !== 16'd1 || rdd[d] !== exp) begin
                errors++;
                $display("FAIL overflow dut%0d: level=%0d drop=%0d head=%h want 16/1/%h",
                         d, lvl[d], drp[d], rdd[d], exp);
            end
        end
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 2; d++) begin
                exp = {4'hF, 30'h100 + 30'(i + d)};
                checks++;
                if (vld[d] !== 1'b1 || rdd[d] !== exp) begin
                    errors++;
                    $display("FAIL drain dut%0d idx%0d: valid=%b data=%h want 1/%h", d, i, vld[d], rdd[d], exp);
                end
            end
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        checks++;
        if (lvl[0] !== 5'd0 || lvl[1] !== 5'd0 || vld[0] !== 1'b0) begin
            errors++;
            $display("FAIL drained: level0=%0d level1=%0d valid0=%b want 0/0/0", lvl[0], lvl[1], vld[0]);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 7; i++) push_word(30'h300 + 30'(i));
        checks++;
        if (lvl[0] !== 5'd7 || drp[0] !== 16'd1) begin
            errors++;
            $display("FAIL pre_clear: level=%0d drop=%0d want 7/1", lvl[0], drp[0]);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lvl[d] !== 5'd0 || vld[d] !== 1'b0 || drp[d] !== 16'd0 || end_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL clear dut%0d: level=%0d valid=%b drop=%0d ended=%b want 0/0/0/0",
                         d, lvl[d], vld[d], drp[d], end_o[d]);
            end
        end
        push_word(30'h3AB);
        checks++;
        if (lvl[0] !== 5'd1 || rdd[0] !== {4'hF, 30'h3AB}) begin
            errors++;
            $display("FAIL after_clear: level=%0d data=%h want 1/%h", lvl[0], rdd[0], {4'hF, 30'h3AB});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) push_word(30'h200 + 30'(i));
        dct_count  = 4'd15;
        dct_buffer = 30'h2FF;
        rd_ready   = 1'b1;
        step();
        rd_ready   = 1'b0;
        dct_count  = 4'd0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lvl[d] !== 5'd16 || drp[d] !== 16'd0 || rdd[d] !== {4'hF, 30'h201}) begin
                errors++;
                $display("FAIL full_push_pop dut%0d: level=%0d drop=%0d head=%h want 16/0/%h",
                         d, lvl[d], drp[d], rdd[d], {4'hF, 30'h201});
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        dct_count   = 4'd5;
        dct_buffer  = 30'h155;
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        checks++;
        if (lvl[0] !== 5'd0 || end_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_entry: level=%0d ended=%b want 0/0", lvl[0], end_o[0]);
        end
        step();
        checks++;
        if (lvl[0] !== 5'd1 || rdd[0] !== {4'h5, 30'h155} || end_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_push: level=%0d data=%h ended=%b want 1/%h/1",
                     lvl[0], rdd[0], end_o[0], {4'h5, 30'h155});
        end
        dct_count = 4'd0;
        step();
        push_word(30'h3FF);
        checks++;
        if (lvl[1] !== 5'd1 || end_o[1] !== 1'b1) begin
            errors++;
            $display("FAIL ended_frozen: level=%0d ended=%b want 1/1", lvl[1], end_o[1]);
        end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        checks++;
        if (lvl[0] !== 5'd0 || end_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL ended_pop: level=%0d ended=%b want 0/1", lvl[0], end_o[0]);
        end
    endtask

    task automatic test_has_ended_priority();
        do_reset();
        dct_count      = 4'd5;
        dct_buffer     = 30'h77;
        test_ending    = 1'b1;
        test_has_ended = 1'b1;
        step();
        test_ending    = 1'b0;
        test_has_ended = 1'b0;
        dct_count      = 4'd0;
        checks++;
        if (end_o[0] !== 1'b1 || lvl[0] !== 5'd0) begin
            errors++;
            $display("FAIL has_ended: ended=%b level=%0d want 1/0", end_o[0], lvl[0]);
        end
        step();
        checks++;
        if (end_o[1] !== 1'b1 || lvl[1] !== 5'd0) begin
            errors++;
            $display("FAIL has_ended_hold: ended=%b level=%0d want 1/0", end_o[1], lvl[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) push_word(30'h400 + 30'(i));
        test_has_ended = 1'b1;
        step();
        test_has_ended = 1'b0;
        checks++;
        if (lvl[0] !== 5'd7 || end_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: level=%0d ended=%b want 7/1", lvl[0], end_o[0]);
        end
        do_reset();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (lvl[d] !== 5'd0 || vld[d] !== 1'b0 || drp[d] !== 16'd0 || end_o[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: level=%0d valid=%b drop=%0d ended=%b want 0/0/0/0",
                         d, lvl[d], vld[d], drp[d], end_o[d]);
            end
        end
        push_word(30'h1234);
        checks++;
        if (lvl[1] !== 5'd1 || rdd[1] !== {4'hF, 30'h1234}) begin
            errors++;
            $display("FAIL after_reset: level=%0d data=%h want 1/%h", lvl[1], rdd[1], {4'hF, 30'h1234});
        end
    endtask

    initial begin
        step();
        test_reset();
        test_single_capture();
        test_full_wrap();
        test_clear();
        test_back_to_back();
        test_flush();
        test_has_ended_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
